booth_divider: RTL and testbench

//   Sequential integer divider; the inverse of the team's Booth multiplier. Computes

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 31 +++
 rtl/booth_divider.sv | 160 ++++++++++++++++
 tb/tb_booth_divider.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : div_pkg                                                     |
// | Brief    : Shared types and constants for the sequential divider.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package div_pkg;

    // Default operand width of the divider datapath
    localparam int C_DEFAULT_W = 8;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Width of a down-counter that must hold the value w
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : div_step                                                    |
// | Brief    : One combinational non-restoring division step on a (W+1)-bit |
// |            signed partial remainder and a W-bit quotient shift reg.    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module div_step
    import div_pkg::*;
#(
    parameter int W = C_DEFAULT_W
) (
    input  logic [W:0]   i_pr,
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_d,
    output logic [W:0]   o_pr,
    output logic [W-1:0] o_q
);

    logic [W:0] w_shift;
    logic [W:0] w_d_ext;

    // The PR stays within [-d, d) after every step, so modular (W+1)-bit
    // arithmetic always yields the exact value even if 2*PR wraps.
    assign w_shift = {i_pr[W-1:0], i_q[W-1]};
    assign w_d_ext = {1'b0, i_d};
    assign o_pr    = i_pr[W] ? (w_shift + w_d_ext) : (w_shift - w_d_ext);
    assign o_q     = {i_q[W-2:0], ~o_pr[W]};

endmodule
`default_nettype wire

// File: rtl/booth_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : booth_divider                                               |
// | Brief    : Sequential non-restoring integer divider, one quotient bit  |
// |            per clock, start/done handshake.                            |
// |            Define DIVIDER_SIGNED_EN for two's complement operands.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module booth_divider
    import div_pkg::*;
#(
    parameter int W = C_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int                 c_cnt_w = cnt_width(W);
    localparam logic [c_cnt_w-1:0] c_steps = c_cnt_w'(W);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [W:0]         r_pr;
    logic [W-1:0]       r_q;
    logic [W-1:0]       r_div;
    logic [W-1:0]       r_dividend;
    logic [W-1:0]       r_quotient;
    logic [W-1:0]       r_remainder;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic               r_zero;

    logic               w_accept;
    logic [W-1:0]       w_dvd_mag;
    logic [W-1:0]       w_dvs_mag;
    logic [W:0]         w_next_pr;
    logic [W-1:0]       w_next_q;
    logic [W-1:0]       w_rem_mag;
    logic [W-1:0]       w_quot_fin;
    logic [W-1:0]       w_rem_fin;

    assign w_accept = (r_state == IDLE) && start;

    // A negative final PR means the last step over-subtracted: add divisor back
    assign w_rem_mag = r_pr[W] ? (r_pr[W-1:0] + r_div) : r_pr[W-1:0];

`ifdef DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Result signs are fixed by the operands seen at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= dividend[W-1] ^ divisor[W-1];
            r_neg_r <= dividend[W-1];
        end
    end

    // Magnitudes; -2^(W-1) maps onto itself, which is its correct unsigned magnitude
    assign w_dvd_mag  = dividend[W-1] ? -dividend : dividend;
    assign w_dvs_mag  = divisor[W-1]  ? -divisor  : divisor;
    assign w_quot_fin = r_neg_q ? -r_q : r_q;
    assign w_rem_fin  = r_neg_r ? -w_rem_mag : w_rem_mag;
`else
    assign w_dvd_mag  = dividend;
    assign w_dvs_mag  = divisor;
    assign w_quot_fin = r_q;
    assign w_rem_fin  = w_rem_mag;
`endif

    div_step #(
        .W (W)
    ) u_step (
        .i_pr (r_pr),
        .i_q  (r_q),
        .i_d  (r_div),
        .o_pr (w_next_pr),
        .o_q  (w_next_q)
    );

    // Control FSM, iteration datapath and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pr        <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_dividend  <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy     <= 1'b1;
                        r_dbz      <= 1'b0;
                        r_cnt      <= c_steps;
                        r_pr       <= '0;
                        r_q        <= w_dvd_mag;
                        r_div      <= w_dvs_mag;
                        r_dividend <= dividend;
                        r_zero     <= (divisor == '0);
                        r_state    <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    r_pr  <= w_next_pr;
                    r_q   <= w_next_q;
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividend;
                        r_dbz       <= 1'b1;
                    end else begin
                        r_quotient  <= w_quot_fin;
                        r_remainder <= w_rem_fin;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_booth_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_booth_divider                                            |
// | Brief    : Self-checking bench for booth_divider (W=8). Expected        |
// |            values follow DIVIDER_SIGNED_EN when it is defined.          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_booth_divider;

    localparam int W   = 8;
    localparam int NV  = 13;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
        string        tag;
    } exp_t;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   n_done = 0;
    exp_t sb[$];

    booth_divider #(
        .W (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        vec_t v;
        v.dvd = dvd; v.dvs = dvs; v.q = q; v.r = r; v.z = z;
        return v;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending op
    always @(negedge clk) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check({e.tag, ".quotient"},  quotient,    e.q);
                check({e.tag, ".remainder"}, remainder,   e.r);
                check({e.tag, ".dbz"},       div_by_zero, e.z);
                check({e.tag, ".latency"},   cyc,         e.due);
                check({e.tag, ".busy_low"},  busy,        0);
            end
        end
    end

    // Drive one request at the current negedge and queue its expected result
    task automatic issue(input vec_t v, input string tag);
        exp_t e;
        dividend = v.dvd;
        divisor  = v.dvs;
        start    = 1'b1;
        e.q   = v.q;
        e.r   = v.r;
        e.z   = v.z;
        e.due = cyc + (v.z ? 2 : W + 2);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s.timeout: got no done within 40 cycles expected done", tag);
            sb.delete();
        end
    endtask

    // Hard stop if something upstream locks the bench
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[NV];
        int   n0;
        int   n;

        tbl[3]  = mk(8'h37, 8'h00, 8'hFF, 8'h37, 1'b1);
        tbl[5]  = mk(8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0);
        tbl[6]  = mk(8'h09, 8'h03, 8'h03, 8'h00, 1'b0);
        tbl[7]  = mk(8'h00, 8'h05, 8'h00, 8'h00, 1'b0);
        tbl[8]  = mk(8'h07, 8'h09, 8'h00, 8'h07, 1'b0);
        tbl[9]  = mk(8'h7F, 8'h02, 8'h3F, 8'h01, 1'b0);
        tbl[10] = mk(8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0);
        tbl[12] = mk(8'h64, 8'h03, 8'h21, 8'h01, 1'b0);
`ifdef DIVIDER_SIGNED_EN
        tbl[0]  = mk(8'hC8, 8'h07, 8'hF8, 8'h00, 1'b0);
        tbl[1]  = mk(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0);
        tbl[2]  = mk(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0);
        tbl[4]  = mk(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        tbl[11] = mk(8'hF6, 8'h03, 8'hFD, 8'hFF, 1'b0);
`else
        tbl[0]  = mk(8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0);
        tbl[1]  = mk(8'h9C, 8'h07, 8'h16, 8'h02, 1'b0);
        tbl[2]  = mk(8'h64, 8'hF9, 8'h00, 8'h64, 1'b0);
        tbl[4]  = mk(8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
        tbl[11] = mk(8'hF6, 8'h03, 8'h52, 8'h00, 1'b0);
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.busy",      busy,        0);
        check("rst.done",      done,        0);
        check("rst.quotient",  quotient,    0);
        check("rst.remainder", remainder,   0);
        check("rst.dbz",       div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table sweep, including divide-by-zero followed by a valid op
        for (int i = 0; i < NV - 1; i++) begin
            issue(tbl[i], $sformatf("vec%0d", i));
            @(negedge clk);
            start = 1'b0;
            check($sformatf("vec%0d.busy_after_accept", i), busy, 1);
            check($sformatf("vec%0d.dbz_after_accept", i), div_by_zero, 0);
            drain($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // start held through busy with operands changing: exactly one result
        n0 = n_done;
        issue(tbl[0], "held");
        repeat (W) begin
            @(negedge clk);
            dividend = 8'h01;
            divisor  = 8'h01;
        end
        @(negedge clk);
        start = 1'b0;
        drain("held");
        repeat (12) @(negedge clk);
        check("held.done_count", n_done - n0, 1);

        // Back-to-back: start in the done cycle
        issue(tbl[6], "b2b_first");
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b2b.first_done_seen", done, 1);
        issue(tbl[0], "b2b_second");
        @(negedge clk);
        start = 1'b0;
        check("b2b.done_dropped", done, 0);
        drain("b2b_second");
        @(negedge clk);

        // Leave a nonzero result, then reset in the 4th CALC cycle
        issue(tbl[5], "pre_rst");
        @(negedge clk);
        start = 1'b0;
        drain("pre_rst");
        @(negedge clk);
        issue(tbl[12], "aborted");
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort.busy",      busy,        0);
        check("abort.done",      done,        0);
        check("abort.quotient",  quotient,    0);
        check("abort.remainder", remainder,   0);
        check("abort.dbz",       div_by_zero, 0);
        n0 = n_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        check("abort.no_done", n_done - n0, 0);
        issue(tbl[6], "post_rst");
        @(negedge clk);
        start = 1'b0;
        drain("post_rst");
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
